// File: rtl/bf_pkg.sv
// ---------------------------------------------------------------------------
// bf_pkg
// Shared definitions for the butterfly input path:
//   - default operand width and lane count
//   - select-field width derivation (clog2 of the lane count, minimum 1)
//   - butterfly operand port numbering: port 2k is u(k), port 2k+1 is v(k)
// ---------------------------------------------------------------------------
package bf_pkg;

  localparam int BF_DATA_W = 12;
  localparam int BF_LANES  = 4;

  // Operand ports are interleaved u0, v0, u1, v1, ...
  localparam int BF_PORTS_PER_BF = 2;
  localparam int BF_U_OFS        = 0;
  localparam int BF_V_OFS        = 1;

  function automatic int sel_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic int u_port(input int k);
    return k * BF_PORTS_PER_BF + BF_U_OFS;
  endfunction

  function automatic int v_port(input int k);
    return k * BF_PORTS_PER_BF + BF_V_OFS;
  endfunction

endpackage

// File: rtl/bf_sel_shift.sv
// ---------------------------------------------------------------------------
// bf_sel_shift
// Enabled shift register of DEPTH stages, W bits wide. Used to delay the
// {sel_vld, sel} bundle so it lines up with the bank read data.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset, clears every stage
//   en_i  - advance enable; 0 holds all stages
//   d_i   - stage-0 input
//   q_o   - last-stage output
// ---------------------------------------------------------------------------
module bf_sel_shift #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/bf_in_router.sv
// ---------------------------------------------------------------------------
// bf_in_router
// Input crossbar from LANES bank read ports to LANES butterfly operand ports.
// The per-lane select is delayed SEL_DLY enabled cycles to meet the bank
// data, then each lane's word is steered to its selected port; when several
// lanes pick the same port the highest lane wins. The routed word is
// registered, so sel->bf_in latency is SEL_DLY+1 and q->bf_in latency is 1.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   en           - pipeline enable, 0 freezes all state
//   sel_vld      - select word valid
//   sel          - per-lane destination port, lane i at [i*SEL_W +: SEL_W]
//   q            - bank read data, lane i at [i*DATA_W +: DATA_W]
//   bf_vld       - bf_in valid
//   bf_in        - operand port p at [p*DATA_W +: DATA_W] (even u, odd v)
//   conflict_now - registered conflict flag for the word on bf_in
//   conflict_err - sticky conflict flag, cleared only by reset
// Build option: define BF_IN_CONFLICT_CHK_EN to implement conflict
// detection; otherwise both conflict outputs are constant 0.
// ---------------------------------------------------------------------------
module bf_in_router
  import bf_pkg::*;
#(
  parameter int DATA_W  = BF_DATA_W,
  parameter int LANES   = BF_LANES,
  parameter int SEL_DLY = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             sel_vld,
  input  logic [LANES*sel_w(LANES)-1:0]    sel,
  input  logic [LANES*DATA_W-1:0]          q,
  output logic                             bf_vld,
  output logic [LANES*DATA_W-1:0]          bf_in,
  output logic                             conflict_now,
  output logic                             conflict_err
);

  localparam int SEL_W = sel_w(LANES);
  localparam int SH_W  = LANES * SEL_W + 1;

  logic [LANES*SEL_W-1:0]  sel_d;
  logic                    vld_d;
  logic [LANES*DATA_W-1:0] xbar_d;
  logic [LANES*DATA_W-1:0] bf_in_q;
  logic                    bf_vld_q;

  // Stage boundary: select delay line
  bf_sel_shift #(
    .W    (SH_W),
    .DEPTH(SEL_DLY)
  ) u_sel_shift (
    .clk  (clk),
    .rst  (rst),
    .en_i (en),
    .d_i  ({sel_vld, sel}),
    .q_o  ({vld_d, sel_d})
  );

  // Lanes are scanned in ascending order so a later lane overwrites an
  // earlier one that chose the same port; unclaimed ports stay 0.
  always_comb begin
    xbar_d = '0;
    for (int p = 0; p < LANES; p++) begin
      for (int i = 0; i < LANES; i++) begin
        if (sel_d[i*SEL_W +: SEL_W] == SEL_W'(p)) begin
          xbar_d[p*DATA_W +: DATA_W] = q[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Stage boundary: output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bf_vld_q <= 1'b0;
      bf_in_q  <= '0;
    end else if (en) begin
      bf_vld_q <= vld_d;
      bf_in_q  <= vld_d ? xbar_d : '0;
    end
  end

  assign bf_vld = bf_vld_q;
  assign bf_in  = bf_in_q;

`ifdef BF_IN_CONFLICT_CHK_EN
  logic dup_d;
  logic conflict_now_d;
  logic conflict_err_d;
  logic conflict_now_q;
  logic conflict_err_q;

  // Any pair of lanes targeting the same port is a conflict.
  always_comb begin
    dup_d = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (sel_d[i*SEL_W +: SEL_W] == sel_d[j*SEL_W +: SEL_W]) dup_d = 1'b1;
      end
    end
  end

  assign conflict_now_d = vld_d & dup_d;
  assign conflict_err_d = conflict_err_q | conflict_now_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_now_q <= 1'b0;
      conflict_err_q <= 1'b0;
    end else if (en) begin
      conflict_now_q <= conflict_now_d;
      conflict_err_q <= conflict_err_d;
    end
  end

  assign conflict_now = conflict_now_q;
  assign conflict_err = conflict_err_q;
`else
  assign conflict_now = 1'b0;
  assign conflict_err = 1'b0;
`endif

endmodule

// File: tb/tb_bf_in_router.sv
// ---------------------------------------------------------------------------
// tb_bf_in_router
// Directed bench for bf_in_router (LANES=4, DATA_W=12, SEL_DLY=2) with a
// reference model keyed on enabled clock edges.
// ---------------------------------------------------------------------------
module tb_bf_in_router;

  localparam int DATA_W  = 12;
  localparam int LANES   = 4;
  localparam int SEL_DLY = 2;
  localparam int SEL_W   = 2;
  localparam int BUS_W   = LANES * DATA_W;
  localparam int LOG_N   = 1024;

`ifdef BF_IN_CONFLICT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic                   sel_vld;
  logic [LANES*SEL_W-1:0] sel;
  logic [BUS_W-1:0]       q;
  logic                   bf_vld;
  logic [BUS_W-1:0]       bf_in;
  logic                   conflict_now;
  logic                   conflict_err;

  bf_in_router #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .SEL_DLY(SEL_DLY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sel_vld     (sel_vld),
    .sel         (sel),
    .q           (q),
    .bf_vld      (bf_vld),
    .bf_in       (bf_in),
    .conflict_now(conflict_now),
    .conflict_err(conflict_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference routing: for every port, search lanes from the top down and
  // take the first one that names it.
  function automatic logic [BUS_W-1:0] ref_route(input logic [LANES*SEL_W-1:0] s,
                                                 input logic [BUS_W-1:0] d);
    logic [BUS_W-1:0] r;
    r = '0;
    for (int p = 0; p < LANES; p++) begin
      for (int i = LANES - 1; i >= 0; i--) begin
        if (int'(s[i*SEL_W +: SEL_W]) == p) begin
          r[p*DATA_W +: DATA_W] = d[i*DATA_W +: DATA_W];
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic bit ref_dup(input logic [LANES*SEL_W-1:0] s);
    int cnt [LANES];
    bit dup;
    dup = 1'b0;
    for (int p = 0; p < LANES; p++) cnt[p] = 0;
    for (int i = 0; i < LANES; i++) cnt[int'(s[i*SEL_W +: SEL_W])]++;
    for (int p = 0; p < LANES; p++) if (cnt[p] > 1) dup = 1'b1;
    return dup;
  endfunction

  // Model: each enabled edge n logs the select; the output after edge n is
  // the select logged SEL_DLY enabled edges earlier applied to q at edge n.
  logic [LANES*SEL_W-1:0] sel_log [LOG_N];
  logic                   vld_log [LOG_N];
  int                     n_edge;
  logic                   exp_vld;
  logic [BUS_W-1:0]       exp_bf;
  logic                   exp_cn;
  logic                   exp_ce;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_edge  <= 0;
      exp_vld <= 1'b0;
      exp_bf  <= '0;
      exp_cn  <= 1'b0;
      exp_ce  <= 1'b0;
    end else if (en) begin
      sel_log[n_edge % LOG_N] <= sel;
      vld_log[n_edge % LOG_N] <= sel_vld;
      n_edge <= n_edge + 1;
      if (n_edge >= SEL_DLY && vld_log[(n_edge - SEL_DLY) % LOG_N]) begin
        exp_vld <= 1'b1;
        exp_bf  <= ref_route(sel_log[(n_edge - SEL_DLY) % LOG_N], q);
        exp_cn  <= CHK & ref_dup(sel_log[(n_edge - SEL_DLY) % LOG_N]);
        exp_ce  <= exp_ce | (CHK & ref_dup(sel_log[(n_edge - SEL_DLY) % LOG_N]));
      end else begin
        exp_vld <= 1'b0;
        exp_bf  <= '0;
        exp_cn  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("bf_vld", 64'(bf_vld), 64'(exp_vld));
    chk("bf_in", 64'(bf_in), 64'(exp_bf));
    chk("conflict_now", 64'(conflict_now), 64'(exp_cn));
    chk("conflict_err", 64'(conflict_err), 64'(exp_ce));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sel_vld = 1'b0;
    sel     = '0;
    q       = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  function automatic logic [BUS_W-1:0] dat(input int k);
    logic [BUS_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = 12'(12'h100 * (k + 1) + i);
    return r;
  endfunction

  logic [7:0] perms [8] = '{8'h1B, 8'hE4, 8'h4E, 8'hB1, 8'h9C, 8'h78, 8'hD2, 8'h63};
  int nvld;

  initial begin
    rst = 1'b1; en = 1'b0; sel_vld = 1'b0; sel = '0; q = '0;
    #2 rst = 1'b0;
    step();
    chk("reset_bf_vld", 64'(bf_vld), 64'd0);
    chk("reset_bf_in", 64'(bf_in), 64'd0);
    chk("reset_conflict_now", 64'(conflict_now), 64'd0);
    chk("reset_conflict_err", 64'(conflict_err), 64'd0);
    step();
    rst = 1'b1;
    en  = 1'b1;
    idle(2);

    // Identity route
    sel = 8'hE4; sel_vld = 1'b1; step();
    sel = '0;    sel_vld = 1'b0; step();
    q = 48'h333_222_111_000; step();
    chk("ident_vld", 64'(bf_vld), 64'd1);
    chk("ident_bf_in", 64'(bf_in), 64'h333_222_111_000);
    chk("ident_conflict", 64'(conflict_now), 64'd0);
    idle(2);

    // Permuted stream, back to back
    nvld = 0;
    for (int t = 0; t < 10; t++) begin
      sel_vld = (t < 8);
      sel     = (t < 8) ? perms[t] : 8'h00;
      q       = (t >= 2) ? dat(t - 2) : '0;
      step();
      if (t >= 2 && bf_vld) nvld++;
      if (t == 2) chk("perm0_bf_in", 64'(bf_in), 64'h100_101_102_103);
    end
    chk("perm_vld_count", 64'(nvld), 64'd8);
    idle(2);

    // Conflict: lanes 3 and 2 both target port 0
    sel = 8'h06; sel_vld = 1'b1; step();
    sel = '0;    sel_vld = 1'b0; step();
    q = 48'hAAA_BBB_111_222; step();
    chk("conf_u0", 64'(bf_in[11:0]), 64'hAAA);
    chk("conf_v0", 64'(bf_in[23:12]), 64'h111);
    chk("conf_u1", 64'(bf_in[35:24]), 64'h222);
    chk("conf_v1", 64'(bf_in[47:36]), 64'h000);
    chk("conf_now", 64'(conflict_now), 64'(CHK));
    q = '0; step();
    chk("conf_now_clear", 64'(conflict_now), 64'd0);
    chk("conf_err_sticky", 64'(conflict_err), 64'(CHK));
    idle(2);

    // Stall with two words in flight
    sel = 8'hE4; sel_vld = 1'b1; step();
    sel = 8'h1B; step();
    sel = 8'h4E; q = 48'h903_902_901_900; step();
    chk("stall_w0", 64'(bf_in), 64'h903_902_901_900);
    en = 1'b0; sel = 8'h06; q = 48'hFFF_FFF_FFF_FFF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_hold_vld", 64'(bf_vld), 64'd1);
      chk("stall_hold_bf_in", 64'(bf_in), 64'h903_902_901_900);
    end
    en = 1'b1; sel_vld = 1'b0; sel = '0; q = 48'hB03_B02_B01_B00; step();
    chk("stall_w1", 64'(bf_in), 64'hB00_B01_B02_B03);
    q = 48'hC03_C02_C01_C00; step();
    chk("stall_w2", 64'(bf_in), 64'hC01_C00_C03_C02);
    idle(2);

    // Invalid select with nonzero data
    sel = 8'hE4; sel_vld = 1'b0; step();
    sel = '0; step();
    q = 48'hFFF_FFF_FFF_FFF; step();
    chk("inv_vld", 64'(bf_vld), 64'd0);
    chk("inv_bf_in", 64'(bf_in), 64'd0);
    idle(2);

    // Mid-stream reset
    sel = 8'h06; sel_vld = 1'b1; step();
    sel = 8'hE4; step();
    sel = 8'h1B; q = 48'h555_666_777_888; step();
    sel_vld = 1'b0; sel = '0;
    rst = 1'b0; #1;
    chk("mrst_vld", 64'(bf_vld), 64'd0);
    chk("mrst_bf_in", 64'(bf_in), 64'd0);
    chk("mrst_conflict_now", 64'(conflict_now), 64'd0);
    chk("mrst_conflict_err", 64'(conflict_err), 64'd0);
    step();
    rst = 1'b1;
    nvld = 0;
    q = 48'h123_456_789_ABC;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bf_vld) nvld++;
    end
    chk("mrst_no_stale", 64'(nvld), 64'd0);
    sel = 8'hE4; sel_vld = 1'b1; q = '0; step();
    sel = '0; sel_vld = 1'b0; step();
    chk("mrst_not_early", 64'(bf_vld), 64'd0);
    q = 48'h444_333_222_111; step();
    chk("mrst_next_vld", 64'(bf_vld), 64'd1);
    chk("mrst_next_bf_in", 64'(bf_in), 64'h444_333_222_111);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
